// File: rtl/decode_pipe.sv
// Y86-64 decode/write-back stage: register-id selection, operand forwarding,
// the 15-entry register file written from W, and the E pipeline register.
module decode_pipe #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RSP   = 4'd4,
    parameter logic [3:0] RNONE = 4'd15
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [1:0]       D_stat,
    input  logic [3:0]       D_in_code,
    input  logic [3:0]       D_in_fun,
    input  logic [3:0]       D_ra,
    input  logic [3:0]       D_rb,
    input  logic [WIDTH-1:0] D_val_c,
    input  logic [WIDTH-1:0] D_val_p,
    input  logic             E_bub,
    input  logic [3:0]       e_dst_e,
    input  logic [WIDTH-1:0] e_val_e,
    input  logic [3:0]       M_dst_e,
    input  logic [WIDTH-1:0] M_val_e,
    input  logic [3:0]       M_dst_m,
    input  logic [WIDTH-1:0] m_val_m,
    input  logic [3:0]       W_dst_e,
    input  logic [WIDTH-1:0] W_val_e,
    input  logic [3:0]       W_dst_m,
    input  logic [WIDTH-1:0] W_val_m,
    output logic [3:0]       d_src_a,
    output logic [3:0]       d_src_b,
    output logic [1:0]       E_stat,
    output logic [3:0]       E_in_code,
    output logic [3:0]       E_in_fun,
    output logic [WIDTH-1:0] E_val_c,
    output logic [WIDTH-1:0] E_val_a,
    output logic [WIDTH-1:0] E_val_b,
    output logic [3:0]       E_dst_e,
    output logic [3:0]       E_dst_m,
    output logic [3:0]       E_src_a,
    output logic [3:0]       E_src_b
);

    logic [WIDTH-1:0] r_regs [0:14];

    logic [3:0]       w_src_a;
    logic [3:0]       w_src_b;
    logic [3:0]       w_dst_e;
    logic [3:0]       w_dst_m;
    logic [1:0]       w_stat;
    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;

    // Nearest in-flight producer wins; the register file is the fallback.
    function automatic logic [WIDTH-1:0] fwd_operand(input logic [3:0] src);
        logic [WIDTH-1:0] v;
        if (src == RNONE)        v = {WIDTH{1'b0}};
        else if (src == e_dst_e) v = e_val_e;
        else if (src == M_dst_m) v = m_val_m;
        else if (src == M_dst_e) v = M_val_e;
        else if (src == W_dst_m) v = W_val_m;
        else if (src == W_dst_e) v = W_val_e;
        else                     v = r_regs[src];
        return v;
    endfunction

    // Register ids from icode; illegal icodes fall to default and keep RNONE.
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (D_in_code)
            4'd2:  begin w_src_a = D_ra; w_dst_e = D_rb; end
            4'd3:  w_dst_e = D_rb;
            4'd4:  begin w_src_a = D_ra; w_src_b = D_rb; end
            4'd5:  begin w_src_b = D_rb; w_dst_m = D_ra; end
            4'd6:  begin w_src_a = D_ra; w_src_b = D_rb; w_dst_e = D_rb; end
            4'd8:  begin w_src_b = RSP;  w_dst_e = RSP; end
            4'd9:  begin w_src_a = RSP;  w_src_b = RSP;  w_dst_e = RSP; end
            4'd10: begin w_src_a = D_ra; w_src_b = RSP;  w_dst_e = RSP; end
            4'd11: begin w_src_a = RSP;  w_src_b = RSP;  w_dst_e = RSP; w_dst_m = D_ra; end
            default: w_src_a = RNONE;
        endcase
    end

    // Status, operand selection and the call/jump return-address path.
    always_comb begin
        if (D_stat != 2'b00)          w_stat = D_stat;
        else if (D_in_code > 4'd11)   w_stat = 2'b11;
        else                          w_stat = 2'b00;
        if (D_in_code == 4'd7 || D_in_code == 4'd8) w_val_a = D_val_p;
        else                                        w_val_a = fwd_operand(w_src_a);
        w_val_b = fwd_operand(w_src_b);
    end

    assign d_src_a = w_src_a;
    assign d_src_b = w_src_b;

    // Register file write port; port M is applied last so it wins on a shared id.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) r_regs[i] <= {WIDTH{1'b0}};
        end else begin
            if (W_dst_e != RNONE) r_regs[W_dst_e] <= W_val_e;
            if (W_dst_m != RNONE) r_regs[W_dst_m] <= W_val_m;
        end
    end

    // E pipeline register: reset and bubble both insert a nop.
    always_ff @(posedge clock) begin
        if (!rst_n || E_bub) begin
            E_stat    <= 2'b00;
            E_in_code <= 4'd1;
            E_in_fun  <= 4'd0;
            E_val_c   <= {WIDTH{1'b0}};
            E_val_a   <= {WIDTH{1'b0}};
            E_val_b   <= {WIDTH{1'b0}};
            E_dst_e   <= RNONE;
            E_dst_m   <= RNONE;
            E_src_a   <= RNONE;
            E_src_b   <= RNONE;
        end else begin
            E_stat    <= w_stat;
            E_in_code <= D_in_code;
            E_in_fun  <= D_in_fun;
            E_val_c   <= D_val_c;
            E_val_a   <= w_val_a;
            E_val_b   <= w_val_b;
            E_dst_e   <= w_dst_e;
            E_dst_m   <= w_dst_m;
            E_src_a   <= w_src_a;
            E_src_b   <= w_src_b;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: a driver queues expected E contents from a
// reference model, a monitor pops and compares them after each clock edge.
module tb_decode_pipe;

    typedef struct {
        logic        rst_n;
        logic [1:0]  stat;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        logic        bub;
        logic [3:0]  ede, mde, mdm, wde, wdm;
        logic [63:0] eve, mve, mvm, wve, wvm;
    } stim_t;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  ic, fn;
        logic [63:0] vc, va, vb;
        logic [3:0]  de, dm, sa, sb;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [1:0]  D_stat;
    logic [3:0]  D_in_code, D_in_fun, D_ra, D_rb;
    logic [63:0] D_val_c, D_val_p;
    logic        E_bub;
    logic [3:0]  e_dst_e, M_dst_e, M_dst_m, W_dst_e, W_dst_m;
    logic [63:0] e_val_e, M_val_e, m_val_m, W_val_e, W_val_m;
    logic [3:0]  d_src_a, d_src_b;
    logic [1:0]  E_stat;
    logic [3:0]  E_in_code, E_in_fun, E_dst_e, E_dst_m, E_src_a, E_src_b;
    logic [63:0] E_val_c, E_val_a, E_val_b;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t        sb_q[$];
    logic [63:0] mregs [15];

    decode_pipe dut (
        .clock(clock), .rst_n(rst_n), .D_stat(D_stat), .D_in_code(D_in_code),
        .D_in_fun(D_in_fun), .D_ra(D_ra), .D_rb(D_rb), .D_val_c(D_val_c),
        .D_val_p(D_val_p), .E_bub(E_bub), .e_dst_e(e_dst_e), .e_val_e(e_val_e),
        .M_dst_e(M_dst_e), .M_val_e(M_val_e), .M_dst_m(M_dst_m), .m_val_m(m_val_m),
        .W_dst_e(W_dst_e), .W_val_e(W_val_e), .W_dst_m(W_dst_m), .W_val_m(W_val_m),
        .d_src_a(d_src_a), .d_src_b(d_src_b), .E_stat(E_stat), .E_in_code(E_in_code),
        .E_in_fun(E_in_fun), .E_val_c(E_val_c), .E_val_a(E_val_a), .E_val_b(E_val_b),
        .E_dst_e(E_dst_e), .E_dst_m(E_dst_m), .E_src_a(E_src_a), .E_src_b(E_src_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.stat = 2'd0; s.ic = 4'd1; s.fn = 4'd0; s.ra = 4'd15; s.rb = 4'd15;
        s.vc = 64'd0; s.vp = 64'd0; s.bub = 1'b0;
        s.ede = 4'd15; s.mde = 4'd15; s.mdm = 4'd15; s.wde = 4'd15; s.wdm = 4'd15;
        s.eve = 64'd0; s.mve = 64'd0; s.mvm = 64'd0; s.wve = 64'd0; s.wvm = 64'd0;
        return s;
    endfunction

    // Operand value as the ISA defines it: newest pending write, else architectural state.
    function automatic logic [63:0] operand(input stim_t s, input logic [3:0] src);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids  = '{s.ede, s.mdm, s.mde, s.wdm, s.wde};
        vals = '{s.eve, s.mvm, s.mve, s.wvm, s.wve};
        if (src == 4'd15) return 64'd0;
        for (int k = 0; k < 5; k++) if (ids[k] == src) return vals[k];
        return mregs[src];
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   ic;
        ic = int'(s.ic);
        e.stat = 2'd0; e.ic = 4'd1; e.fn = 4'd0; e.vc = 64'd0; e.va = 64'd0; e.vb = 64'd0;
        e.sa = (ic inside {2, 4, 6, 10}) ? s.ra : (ic inside {9, 11}) ? 4'd4 : 4'd15;
        e.sb = (ic inside {4, 5, 6}) ? s.rb : (ic inside {8, 9, 10, 11}) ? 4'd4 : 4'd15;
        e.de = (ic inside {2, 3, 6}) ? s.rb : (ic inside {8, 9, 10, 11}) ? 4'd4 : 4'd15;
        e.dm = (ic inside {5, 11}) ? s.ra : 4'd15;
        if (ic > 11) begin
            e.sa = 4'd15; e.sb = 4'd15; e.de = 4'd15; e.dm = 4'd15;
        end
        if (s.rst_n && !s.bub) begin
            e.stat = (s.stat != 2'd0) ? s.stat : (ic > 11) ? 2'd3 : 2'd0;
            e.ic = s.ic; e.fn = s.fn; e.vc = s.vc;
            e.va = (ic == 7 || ic == 8) ? s.vp : operand(s, e.sa);
            e.vb = operand(s, e.sb);
        end else begin
            e.de = 4'd15; e.dm = 4'd15; e.sa = 4'd15; e.sb = 4'd15;
        end
        return e;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clock);
        rst_n = s.rst_n; D_stat = s.stat; D_in_code = s.ic; D_in_fun = s.fn;
        D_ra = s.ra; D_rb = s.rb; D_val_c = s.vc; D_val_p = s.vp; E_bub = s.bub;
        e_dst_e = s.ede; e_val_e = s.eve; M_dst_e = s.mde; M_val_e = s.mve;
        M_dst_m = s.mdm; m_val_m = s.mvm; W_dst_e = s.wde; W_val_e = s.wve;
        W_dst_m = s.wdm; W_val_m = s.wvm;
        e = model(s);
        sb_q.push_back(e);
        #1;
        if (s.ic <= 4'd11 || s.rst_n) begin
            chk("d_src_a", {60'd0, d_src_a}, {60'd0, model_src_a(s)});
            chk("d_src_b", {60'd0, d_src_b}, {60'd0, model_src_b(s)});
        end
        if (!s.rst_n) begin
            for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
        end else begin
            if (s.wde != 4'd15) mregs[s.wde] = s.wve;
            if (s.wdm != 4'd15) mregs[s.wdm] = s.wvm;
        end
    endtask

    function automatic logic [3:0] model_src_a(input stim_t s);
        stim_t t;
        t = s; t.rst_n = 1'b1; t.bub = 1'b0;
        return model(t).sa;
    endfunction

    function automatic logic [3:0] model_src_b(input stim_t s);
        stim_t t;
        t = s; t.rst_n = 1'b1; t.bub = 1'b0;
        return model(t).sb;
    endfunction

    // Monitor: E is loaded on every edge, so each edge retires one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("E_stat",    {62'd0, E_stat},    {62'd0, e.stat});
                chk("E_in_code", {60'd0, E_in_code}, {60'd0, e.ic});
                chk("E_in_fun",  {60'd0, E_in_fun},  {60'd0, e.fn});
                chk("E_val_c",   E_val_c, e.vc);
                chk("E_val_a",   E_val_a, e.va);
                chk("E_val_b",   E_val_b, e.vb);
                chk("E_dst_e",   {60'd0, E_dst_e},   {60'd0, e.de});
                chk("E_dst_m",   {60'd0, E_dst_m},   {60'd0, e.dm});
                chk("E_src_a",   {60'd0, E_src_a},   {60'd0, e.sa});
                chk("E_src_b",   {60'd0, E_src_b},   {60'd0, e.sb});
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
        s = idle(); s.rst_n = 1'b0;
        drive(s); drive(s);

        // irmovq $0x10,%rax retires, then rrmovq %rax,%rbx
        s = idle(); s.wde = 4'd0; s.wve = 64'h10; drive(s);
        s = idle(); s.ic = 4'd2; s.ra = 4'd0; s.rb = 4'd3; drive(s);
        chk("t1_rax_fwd_model", mregs[0], 64'h10);

        // execute-stage forward beats memory-stage forward
        s = idle(); s.ic = 4'd6; s.ra = 4'd2; s.rb = 4'd1;
        s.ede = 4'd2; s.eve = 64'd5; s.mde = 4'd2; s.mve = 64'd7; drive(s);

        // popq %rsp: port M wins, then call reads the new %rsp
        s = idle(); s.wde = 4'd4; s.wve = 64'h108; s.wdm = 4'd4; s.wvm = 64'h55; drive(s);
        s = idle(); s.ic = 4'd8; s.vc = 64'h40; s.vp = 64'h29; drive(s);
        s.bub = 1'b1; drive(s);

        // illegal icode and halt status
        s = idle(); s.ic = 4'd12; s.ra = 4'd3; s.rb = 4'd4; drive(s);
        s = idle(); s.ic = 4'd0; s.stat = 2'd1; drive(s);

        // reset mid-stream with a W write pending, then read every register
        s = idle(); s.wde = 4'd7; s.wve = 64'hAA; drive(s);
        s = idle(); s.rst_n = 1'b0; s.ic = 4'd6; s.ra = 4'd4; s.rb = 4'd5;
        s.wde = 4'd8; s.wve = 64'hBB; drive(s);
        for (int r = 0; r < 15; r += 2) begin
            s = idle(); s.ic = 4'd6; s.ra = 4'(r); s.rb = 4'(r + 1); drive(s);
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.bub   = ($urandom_range(0, 9) == 0);
            s.stat  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            s.ic = 4'($urandom_range(0, 15)); s.fn = 4'($urandom_range(0, 15));
            s.ra = 4'($urandom_range(0, 15)); s.rb = 4'($urandom_range(0, 15));
            s.vc = {$urandom, $urandom}; s.vp = {$urandom, $urandom};
            s.ede = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
            s.mde = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
            s.mdm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
            s.wde = 4'($urandom_range(0, 15)); s.wdm = 4'($urandom_range(0, 15));
            s.eve = {$urandom, $urandom}; s.mve = {$urandom, $urandom};
            s.mvm = {$urandom, $urandom}; s.wve = {$urandom, $urandom};
            s.wvm = {$urandom, $urandom};
            drive(s);
        end

        s = idle(); drive(s);
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clock);
        #2;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
